// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: op encodings, FSM states
// and the request legality rule.
package mem_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MERGE = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  // Unsigned ops exist only for loads; halves need even, words need 4-aligned addresses.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] op,
                                        input logic [1:0] lane,
                                        input logic       in_range);
    logic ok;
    case (op)
      OP_B:    ok = 1'b1;
      OP_H:    ok = ~lane[0];
      OP_W:    ok = (lane == 2'b00);
      OP_BU:   ok = ~is_store;
      OP_HU:   ok = ~is_store & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok & in_range;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends a sub-word load and merges a
// sub-word store into the previously read word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_store_data,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_op,
  output logic [31:0] o_load_value,
  output logic [31:0] o_merged_word
);

  logic       w_is_byte;
  logic       w_is_half;
  logic       w_signed;
  logic [7:0] w_bytes [4];
  logic [7:0] w_sel_byte;
  logic [15:0] w_sel_half;

  assign w_is_byte = (i_op == OP_B) || (i_op == OP_BU);
  assign w_is_half = (i_op == OP_H) || (i_op == OP_HU);
  assign w_signed  = (i_op == OP_B) || (i_op == OP_H);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_hit;
      logic [7:0] w_src;

      assign w_bytes[gi] = i_word[8*gi +: 8];
      assign w_hit = w_is_byte ? (i_lane == LANE) :
                     w_is_half ? (i_lane[1] == LANE[1]) : 1'b1;
      // Store data always arrives right-justified, so a half's high byte is bits 15:8.
      assign w_src = w_is_byte ? i_store_data[7:0] :
                     w_is_half ? i_store_data[8*(gi%2) +: 8] : i_store_data[8*gi +: 8];
      assign o_merged_word[8*gi +: 8] = w_hit ? w_src : w_bytes[gi];
    end
  endgenerate

  assign w_sel_byte = w_bytes[i_lane];
  assign w_sel_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_value = i_word;
    if (w_is_byte) begin
      o_load_value = {{24{w_signed & w_sel_byte[7]}}, w_sel_byte};
    end else if (w_is_half) begin
      o_load_value = {{16{w_signed & w_sel_half[15]}}, w_sel_half};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for a word-addressed data memory with a one-cycle registered
// read: byte-addressed loads/stores, read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_is_store,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_store_data,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_error,
  output logic [31:0]       o_load_data,
  output logic [31:0]       o_mem_address,
  output logic [31:0]       o_mem_write_data,
  output logic              o_mem_write_enable,
  output logic              o_mem_read,
  input  logic [31:0]       i_mem_read_data
);

  state_e      r_state;
  logic        r_is_store;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_word_idx;
  logic [31:0] r_store_data;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_error;

  logic [31:0] w_req_word;
  logic        w_in_range;
  logic        w_legal;
  logic [31:0] w_load_value;
  logic [31:0] w_merged_word;

  assign w_req_word = 32'(i_addr >> 2);
  assign w_in_range = (w_req_word < 32'(MEM_WORDS));
  assign w_legal    = access_legal(i_is_store, i_op, i_addr[1:0], w_in_range);

  mem_lane_align u_lane_align (
    .i_word        (i_mem_read_data),
    .i_store_data  (r_store_data),
    .i_lane        (r_lane),
    .i_op          (r_op),
    .o_load_value  (w_load_value),
    .o_merged_word (w_merged_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_is_store   <= 1'b0;
      r_op         <= '0;
      r_lane       <= '0;
      r_word_idx   <= '0;
      r_store_data <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_is_store   <= i_is_store;
            r_op         <= i_op;
            r_lane       <= i_addr[1:0];
            r_word_idx   <= w_req_word;
            r_store_data <= i_store_data;
            if (!w_legal) begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else if (i_is_store && (i_op == OP_W)) begin
              r_wdata <= i_store_data;
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: r_state <= ST_MERGE;
        ST_MERGE: begin
          if (r_is_store) begin
            r_wdata <= w_merged_word;
            r_state <= ST_WRITE;
          end else begin
            r_load_data <= w_load_value;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asserted reset removes them at once.
  assign o_ready            = (r_state == ST_IDLE);
  assign o_mem_read         = (r_state == ST_READ);
  assign o_mem_write_enable = (r_state == ST_WRITE);
  assign o_mem_address      = (r_state == ST_IDLE) ? 32'd0 : r_word_idx;
  assign o_mem_write_data   = (r_state == ST_WRITE) ? r_wdata : 32'd0;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_load_data        = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus randomized
// traffic checked against a word-array reference model.
module tb_mem_access_unit;

  localparam int MW = 1024;
  localparam int PRELOAD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        ready, done, error, mem_we, mem_read;
  logic [31:0] load_data, mem_address, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  mem_access_unit #(.MEM_WORDS(MW), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_is_store(is_store), .i_op(op),
    .i_addr(addr), .i_store_data(store_data), .o_ready(ready), .o_done(done),
    .o_error(error), .o_load_data(load_data), .o_mem_address(mem_address),
    .o_mem_write_data(mem_wdata), .o_mem_write_enable(mem_we), .o_mem_read(mem_read),
    .i_mem_read_data(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory (registered read) with a backdoor write port for preloading.
  logic [31:0] mem [MW];
  logic        bd_we = 1'b0;
  int          bd_idx = 0;
  logic [31:0] bd_data = 32'd0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (mem_read && mem_address < MW) mem_rdata <= mem[mem_address];
    if (mem_we && mem_address < MW) mem[mem_address] <= mem_wdata;
  end

  // Strobe monitor.
  int          rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, err_wo_done = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;
  int          log_enc = 0;
  always @(negedge clk) begin
    if (mem_read) begin rd_cnt++; last_rd_addr = mem_address; log_enc = log_enc * 4 + 1; end
    if (mem_we) begin wr_cnt++; last_wr_addr = mem_address; last_wr_data = mem_wdata; log_enc = log_enc * 4 + 2; end
    if (mem_read && mem_we) overlap_cnt++;
    if (error && !done) err_wo_done++;
  end

  int          n_checks = 0, n_errors = 0;
  logic [31:0] ref_mem [MW];
  logic [31:0] last_ld = 32'd0;

  // ---------------- reference model (plain arithmetic on the rules) ----------
  function automatic logic m_legal(input logic st, input logic [2:0] o, input logic [31:0] a);
    if ((a >> 2) >= MW) return 1'b0;
    case (o)
      3'd0: return 1'b1;
      3'd1: return a % 2 == 0;
      3'd2: return a % 4 == 0;
      3'd4: return !st;
      3'd5: return !st && (a % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] o);
    return (o == 3'd0 || o == 3'd4) ? 1 : (o == 3'd1 || o == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] o);
    longint unsigned mask, v;
    int sz = m_size(o);
    int sh = 8 * (a % 4);
    mask = (64'd1 << (8 * sz)) - 1;
    v = (longint'(w) >> sh) & mask;
    if (o < 3'd4 && sz < 4 && v >= (mask + 1) / 2) v = v | (~mask);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a, input logic [2:0] o, input logic [31:0] d);
    longint unsigned mask, v;
    int sh = 8 * (a % 4);
    mask = (64'd1 << (8 * m_size(o))) - 1;
    v = (longint'(w) & ~(mask << sh)) | ((longint'(d) & mask) << sh);
    return v[31:0];
  endfunction

  // ---------------- driver ---------------------------------------------------
  task automatic run_txn(input logic st, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic err,
                         output logic [31:0] ld);
    lat = 0; err = 1'bx; ld = 32'hx;
    @(negedge clk);
    req = 1'b1; is_store = st; op = o; addr = a; store_data = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin lat = n; err = error; ld = load_data; break; end
    end
    $display("txn st=%0d op=%0d addr=%h data=%h lat=%0d err=%0d ld=%h", st, o, a, d, lat, err, ld);
  endtask

  task automatic backdoor(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = val;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < PRELOAD; i++) backdoor(i, $urandom());
    #1;
    n_checks++; if (ready !== 1'b0 && ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_x got %b exp 1", ready); end
    n_checks++; if ({mem_read, mem_we} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes got %b exp 00", {mem_read, mem_we}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    n_checks++; if ({done, error} !== 2'b00) begin n_errors++; $display("FAIL reset_done_err got %b exp 00", {done, error}); end
    n_checks++; if (load_data !== 32'd0) begin n_errors++; $display("FAIL reset_load_data got %h exp 0", load_data); end
    n_checks++; if (mem_address !== 32'd0 || mem_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_idle_bus got addr %h wdata %h exp 0 0", mem_address, mem_wdata); end
  endtask

  typedef struct { logic [2:0] o; logic [31:0] a; logic [31:0] exp; } ld_case_t;

  task automatic test_loads();
    ld_case_t tbl [6];
    int lat; logic err; logic [31:0] ld; int rd0, wr0;
    tbl[0] = '{3'd0, 32'h15, 32'h0000007F};
    tbl[1] = '{3'd4, 32'h17, 32'h00000080};
    tbl[2] = '{3'd0, 32'h17, 32'hFFFFFF80};
    tbl[3] = '{3'd1, 32'h16, 32'hFFFF80FF};
    tbl[4] = '{3'd5, 32'h16, 32'h000080FF};
    tbl[5] = '{3'd2, 32'h14, 32'h80FF7F01};
    backdoor(5, 32'h80FF7F01);
    foreach (tbl[i]) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_txn(1'b0, tbl[i].o, tbl[i].a, 32'd0, lat, err, ld);
      n_checks++; if (lat !== 3 || err !== 1'b0) begin n_errors++; $display("FAIL load%0d_timing got lat %0d err %b exp 3 0", i, lat, err); end
      n_checks++; if (ld !== tbl[i].exp) begin n_errors++; $display("FAIL load%0d_data got %h exp %h", i, ld, tbl[i].exp); end
      n_checks++; if (rd_cnt - rd0 !== 1 || wr_cnt !== wr0 || last_rd_addr !== 32'd5) begin n_errors++; $display("FAIL load%0d_strobes got rd %0d wr %0d addr %h exp 1 0 5", i, rd_cnt - rd0, wr_cnt - wr0, last_rd_addr); end
      last_ld = tbl[i].exp;
    end
  endtask

  task automatic test_stores();
    int lat; logic err; logic [31:0] ld; int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, lat, err, ld);
    n_checks++; if (lat !== 2 || err !== 1'b0) begin n_errors++; $display("FAIL sw_timing got lat %0d err %b exp 2 0", lat, err); end
    n_checks++; if (wr_cnt - wr0 !== 1 || rd_cnt !== rd0 || last_wr_addr !== 32'd8 || last_wr_data !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL sw_strobes got wr %0d rd %0d addr %h data %h exp 1 0 8 deadbeef", wr_cnt - wr0, rd_cnt - rd0, last_wr_addr, last_wr_data); end
    ref_mem[8] = 32'hDEADBEEF;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b1, 3'd0, 32'h22, 32'hAAAAAA55, lat, err, ld);
    n_checks++; if (lat !== 4 || err !== 1'b0) begin n_errors++; $display("FAIL sb_timing got lat %0d err %b exp 4 0", lat, err); end
    n_checks++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 1 || last_wr_data !== 32'hDE55BEEF) begin
      n_errors++; $display("FAIL sb_merge got wr %0d rd %0d data %h exp 1 1 de55beef", wr_cnt - wr0, rd_cnt - rd0, last_wr_data); end
    n_checks++; if (ld !== last_ld) begin n_errors++; $display("FAIL store_ld_held got %h exp %h", ld, last_ld); end
    ref_mem[8] = 32'hDE55BEEF;
  endtask

  task automatic test_illegal();
    logic st_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] op_t [4] = '{3'd1, 3'd2, 3'd4, 3'd2};
    logic [31:0] ad_t [4] = '{32'h13, 32'h22, 32'h14, 32'h1000};
    int lat; logic err; logic [31:0] ld; int rd0, wr0;
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_txn(st_t[i], op_t[i], ad_t[i], 32'h12345678, lat, err, ld);
      n_checks++; if (lat !== 1 || err !== 1'b1) begin n_errors++; $display("FAIL illegal%0d_resp got lat %0d err %b exp 1 1", i, lat, err); end
      n_checks++; if (rd_cnt !== rd0 || wr_cnt !== wr0 || ld !== last_ld) begin
        n_errors++; $display("FAIL illegal%0d_side got rd %0d wr %0d ld %h exp 0 0 %h", i, rd_cnt - rd0, wr_cnt - wr0, ld, last_ld); end
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, rd0, wr0, exp_rd, exp_wr; logic err; logic [31:0] ld, exp_ld, a, d, w;
    logic st, ok; logic [2:0] o;
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 9) == 0) ? MW + $urandom_range(0, 4) : $urandom_range(0, 31);
      a = (w << 2) | $urandom_range(0, 3);
      d = $urandom();
      ok = m_legal(st, o, a);
      exp_ld = last_ld; exp_rd = 0; exp_wr = 0;
      if (!ok) exp_lat = 1;
      else if (st && o == 3'd2) begin exp_lat = 2; exp_wr = 1; end
      else if (st) begin exp_lat = 4; exp_rd = 1; exp_wr = 1; end
      else begin exp_lat = 3; exp_rd = 1; exp_ld = m_load(ref_mem[w], a, o); end
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_txn(st, o, a, d, lat, err, ld);
      n_checks++; if (lat !== exp_lat || err !== !ok) begin n_errors++; $display("FAIL rnd%0d_resp got lat %0d err %b exp %0d %b", t, lat, err, exp_lat, !ok); end
      n_checks++; if (ld !== exp_ld) begin n_errors++; $display("FAIL rnd%0d_ld got %h exp %h", t, ld, exp_ld); end
      n_checks++; if (rd_cnt - rd0 !== exp_rd || wr_cnt - wr0 !== exp_wr) begin n_errors++; $display("FAIL rnd%0d_strobes got rd %0d wr %0d exp %0d %0d", t, rd_cnt - rd0, wr_cnt - wr0, exp_rd, exp_wr); end
      if (ok && st) begin
        ref_mem[w] = (o == 3'd2) ? d : m_merge(ref_mem[w], a, o, d);
        n_checks++; if (last_wr_addr !== w || last_wr_data !== ref_mem[w]) begin n_errors++; $display("FAIL rnd%0d_write got addr %h data %h exp %h %h", t, last_wr_addr, last_wr_data, w, ref_mem[w]); end
      end
      if (ok && !st) last_ld = exp_ld;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [31:0] ld; int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; op = 3'd1; addr = 32'h30; store_data = 32'h0000A5C3;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_read, mem_we} !== 2'b00) begin n_errors++; $display("FAIL rstmid_strobes got %b exp 00", {mem_read, mem_we}); end
    n_checks++; if ({done, error} !== 2'b00 || load_data !== 32'd0 || mem_address !== 32'd0 || mem_wdata !== 32'd0) begin
      n_errors++; $display("FAIL rstmid_outputs got done %b err %b ld %h addr %h wd %h exp all 0", done, error, load_data, mem_address, mem_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (wr_cnt !== wr0 || mem[12] !== ref_mem[12]) begin n_errors++; $display("FAIL rstmid_nowrite got wr %0d word %h exp 0 %h", wr_cnt - wr0, mem[12], ref_mem[12]); end
    last_ld = 32'd0;
    run_txn(1'b0, 3'd2, 32'h30, 32'd0, lat, err, ld);
    n_checks++; if (lat !== 3 || err !== 1'b0 || ld !== ref_mem[12]) begin n_errors++; $display("FAIL rstmid_recover got lat %0d err %b ld %h exp 3 0 %h", lat, err, ld, ref_mem[12]); end
    last_ld = ref_mem[12];
  endtask

  task automatic test_back_to_back();
    logic st_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ad_t [3] = '{32'h14, 32'h30, 32'h40};
    int gap_t [3] = '{3, 3, 2};
    logic [31:0] d, exp_ld;
    int idx = 0, gap = 0;
    d = $urandom();
    log_enc = 0;
    @(negedge clk);
    req = 1'b1; is_store = st_t[0]; op = 3'd2; addr = ad_t[0]; store_data = d;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        $display("b2b txn %0d st=%0d addr=%h gap=%0d ld=%h", idx, st_t[idx], ad_t[idx], gap, load_data);
        n_checks++; if (gap !== gap_t[idx] || error !== 1'b0) begin n_errors++; $display("FAIL b2b%0d_gap got %0d err %b exp %0d 0", idx, gap, error, gap_t[idx]); end
        if (!st_t[idx]) begin
          exp_ld = ref_mem[ad_t[idx] >> 2];
          n_checks++; if (load_data !== exp_ld) begin n_errors++; $display("FAIL b2b%0d_ld got %h exp %h", idx, load_data, exp_ld); end
        end
        idx++;
        gap = 0;
        if (idx < 3) begin is_store = st_t[idx]; addr = ad_t[idx]; end
        else req = 1'b0;
      end
    end
    req = 1'b0;
    n_checks++; if (idx !== 3) begin n_errors++; $display("FAIL b2b_timeout got %0d done exp 3", idx); end
    ref_mem[16] = d;
    repeat (3) @(negedge clk);
    n_checks++; if (log_enc !== 22 || overlap_cnt !== 0) begin n_errors++; $display("FAIL b2b_order got log %0d overlap %0d exp 22 0", log_enc, overlap_cnt); end
  endtask

  task automatic test_final_state();
    int bad = 0;
    for (int i = 0; i < PRELOAD; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL mem_contents got %0d bad words exp 0", bad); end
    n_checks++; if (overlap_cnt !== 0 || err_wo_done !== 0) begin n_errors++; $display("FAIL strobe_rules got overlap %0d err_wo_done %0d exp 0 0", overlap_cnt, err_wo_done); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_final_state();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
